// File: rtl/ramdisk_store.sv
// ramdisk_store -- RAM-backed block store answering to one drive number.
//
// Purpose:
//   Holds BLOCKS blocks of 256 x 16-bit words in a single-port synchronous
//   RAM. The host streams block data through a 512-word write FIFO and reads
//   it back through a 512-word first-word-fall-through read FIFO. A command
//   pulse (sd_read / sd_write) copies one whole block between the RAM and
//   the matching FIFO.
//
// Ports:
//   clk, reset          20 MHz clock, synchronous active-high reset
//   sd_dev_sel, sd_lba  drive select and linear block address of a command
//   sd_read, sd_write   one-cycle command pulses (write wins if both)
//   sd_ready            high only while idle and able to take a command
//   sd_write_data/_enable/_full   write FIFO push side
//   sd_read_data/_enable/_empty   read FIFO pop side (head shown combinationally)
//   sd_loaded           one-hot UNIT bit
//   sd_write_protect    UNIT bit mirrors the registered wp_switch
//   wp_switch           front-panel write protect
//   sd_error            one-cycle pulse on a rejected or write-protected command
//   o_dbg_state         current transfer state (IDLE / WR_XFER / RD_XFER)
//
// Handshake: a FIFO push happens on a cycle where the enable is high and the
// FIFO is not full; a pop happens where the enable is high and the FIFO is
// not empty. Any other enable is silently ignored. Commands are accepted only
// on a cycle where sd_ready is high.
//
// Configuration:
//   RAMDISK_BOUNDS_EN  defined   -> commands with sd_lba >= BLOCKS are rejected
//                      undefined -> block = sd_lba modulo BLOCKS
module ramdisk_store #(
  parameter int UNIT   = 0,
  parameter int BLOCKS = 48
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  sd_dev_sel,
  input  logic [12:0] sd_lba,
  input  logic        sd_read,
  input  logic        sd_write,
  output logic        sd_ready,
  input  logic [15:0] sd_write_data,
  input  logic        sd_write_enable,
  output logic        sd_write_full,
  output logic [15:0] sd_read_data,
  input  logic        sd_read_enable,
  output logic        sd_read_empty,
  output logic [7:0]  sd_loaded,
  output logic [7:0]  sd_write_protect,
  input  logic        wp_switch,
  output logic        sd_error,
  output logic [1:0]  o_dbg_state
);

  localparam int BW    = (BLOCKS > 1) ? $clog2(BLOCKS) : 1;
  localparam int AW    = BW + 8;
  localparam int DEPTH = BLOCKS * 256;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WR_XFER = 2'd1,
    RD_XFER = 2'd2
  } state_t;

  state_t      r_state;
  logic        r_ready;
  logic        r_error;
  logic [7:0]  r_word;
  logic [BW-1:0] r_block;
  logic        r_wp_lat;
  logic        r_wp;
  logic        r_issue_done;
  logic        r_inflight;
  logic        r_inflight_last;

  // ---------------- write FIFO ----------------
  logic [15:0] r_wf_mem [0:511];
  logic [8:0]  r_wf_wptr, r_wf_rptr;
  logic [9:0]  r_wf_count;
  logic        w_wf_empty, w_wf_full, w_wf_push, w_wf_pop;
  logic [15:0] w_wf_head;

  assign w_wf_empty = (r_wf_count == 10'd0);
  assign w_wf_full  = (r_wf_count == 10'd512);
  assign w_wf_push  = sd_write_enable && !w_wf_full;
  assign w_wf_pop   = (r_state == WR_XFER) && !w_wf_empty;
  assign w_wf_head  = r_wf_mem[r_wf_rptr];

  always_ff @(posedge clk) begin
    if (w_wf_push) r_wf_mem[r_wf_wptr] <= sd_write_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wf_wptr  <= 9'd0;
      r_wf_rptr  <= 9'd0;
      r_wf_count <= 10'd0;
    end else begin
      if (w_wf_push) r_wf_wptr <= r_wf_wptr + 9'd1;
      if (w_wf_pop)  r_wf_rptr <= r_wf_rptr + 9'd1;
      case ({w_wf_push, w_wf_pop})
        2'b10:   r_wf_count <= r_wf_count + 10'd1;
        2'b01:   r_wf_count <= r_wf_count - 10'd1;
        default: r_wf_count <= r_wf_count;
      endcase
    end
  end

  // ---------------- read FIFO ----------------
  logic [15:0] r_rf_mem [0:511];
  logic [8:0]  r_rf_wptr, r_rf_rptr;
  logic [9:0]  r_rf_count;
  logic        w_rf_empty, w_rf_full, w_rf_push, w_rf_pop;
  logic [15:0] r_ram_q;

  assign w_rf_empty = (r_rf_count == 10'd0);
  assign w_rf_full  = (r_rf_count == 10'd512);
  // The RAM output register holds the in-flight word until the FIFO has room.
  assign w_rf_push  = (r_state == RD_XFER) && r_inflight && !w_rf_full;
  assign w_rf_pop   = sd_read_enable && !w_rf_empty;

  always_ff @(posedge clk) begin
    if (w_rf_push) r_rf_mem[r_rf_wptr] <= r_ram_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rf_wptr  <= 9'd0;
      r_rf_rptr  <= 9'd0;
      r_rf_count <= 10'd0;
    end else begin
      if (w_rf_push) r_rf_wptr <= r_rf_wptr + 9'd1;
      if (w_rf_pop)  r_rf_rptr <= r_rf_rptr + 9'd1;
      case ({w_rf_push, w_rf_pop})
        2'b10:   r_rf_count <= r_rf_count + 10'd1;
        2'b01:   r_rf_count <= r_rf_count - 10'd1;
        default: r_rf_count <= r_rf_count;
      endcase
    end
  end

  // ---------------- block RAM ----------------
  logic [15:0]   r_ram [0:DEPTH-1];
  logic [AW-1:0] w_ram_addr;
  logic          w_ram_we, w_rd_issue;

  assign w_ram_addr = {r_block, r_word};
  // A protected write still drains the FIFO but never touches the RAM.
  assign w_ram_we   = w_wf_pop && !r_wp_lat;
  // Issue the next read only when the output register is free or being
  // emptied into the FIFO this same cycle.
  assign w_rd_issue = (r_state == RD_XFER) && !r_issue_done &&
                      (!r_inflight || w_rf_push);

  // No reset: disk contents survive reset.
  always_ff @(posedge clk) begin
    if (w_ram_we)   r_ram[w_ram_addr] <= w_wf_head;
    if (w_rd_issue) r_ram_q <= r_ram[w_ram_addr];
  end

  // ---------------- command decode ----------------
  logic          w_cmd, w_bad;
  logic [BW-1:0] w_cmd_block;
  logic [12:0]   w_lba_mod;

  assign w_cmd       = sd_read || sd_write;
  assign w_lba_mod   = sd_lba % 13'(BLOCKS);
  assign w_cmd_block = w_lba_mod[BW-1:0];
`ifdef RAMDISK_BOUNDS_EN
  assign w_bad = (sd_dev_sel != 3'(UNIT)) || (sd_lba >= 13'(BLOCKS));
`else
  assign w_bad = (sd_dev_sel != 3'(UNIT));
`endif

  // ---------------- transfer FSM ----------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state         <= IDLE;
      r_ready         <= 1'b1;
      r_error         <= 1'b0;
      r_word          <= 8'd0;
      r_block         <= '0;
      r_wp_lat        <= 1'b0;
      r_issue_done    <= 1'b0;
      r_inflight      <= 1'b0;
      r_inflight_last <= 1'b0;
    end else begin
      r_error <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_cmd) begin
            if (w_bad) begin
              r_error <= 1'b1;
            end else begin
              r_block         <= w_cmd_block;
              r_word          <= 8'd0;
              r_wp_lat        <= wp_switch;
              r_issue_done    <= 1'b0;
              r_inflight      <= 1'b0;
              r_inflight_last <= 1'b0;
              r_ready         <= 1'b0;
              r_state         <= sd_write ? WR_XFER : RD_XFER;
            end
          end
        end
        WR_XFER: begin
          if (w_wf_pop) begin
            r_word <= r_word + 8'd1;
            if (r_word == 8'hFF) begin
              r_state <= IDLE;
              r_ready <= 1'b1;
              r_error <= r_wp_lat;
            end
          end
        end
        RD_XFER: begin
          if (w_rd_issue) begin
            r_word          <= r_word + 8'd1;
            r_inflight      <= 1'b1;
            r_inflight_last <= (r_word == 8'hFF);
            if (r_word == 8'hFF) r_issue_done <= 1'b1;
          end else if (w_rf_push) begin
            r_inflight <= 1'b0;
          end
          if (w_rf_push && r_inflight_last) begin
            r_state <= IDLE;
            r_ready <= 1'b1;
          end
        end
        default: begin
          r_state <= IDLE;
          r_ready <= 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) r_wp <= 1'b0;
    else       r_wp <= wp_switch;
  end

  assign sd_ready         = r_ready;
  assign sd_error         = r_error;
  assign sd_write_full    = w_wf_full;
  assign sd_read_empty    = w_rf_empty;
  assign sd_read_data     = r_rf_mem[r_rf_rptr];
  assign sd_loaded        = 8'd1 << UNIT;
  assign sd_write_protect = 8'(r_wp) << UNIT;
  assign o_dbg_state      = r_state;

endmodule

// File: tb/tb_ramdisk_store.sv
// tb_ramdisk_store -- randomized self-checking bench for ramdisk_store.
// The reference model is a flat word array for the disk, a queue for the
// write FIFO contents, and an expected queue of words the read FIFO must
// deliver, all updated at command level.
module tb_ramdisk_store;

  localparam int BLOCKS = 48;

  logic        clk;
  logic        reset;
  logic [2:0]  sd_dev_sel;
  logic [12:0] sd_lba;
  logic        sd_read;
  logic        sd_write;
  logic        sd_ready;
  logic [15:0] sd_write_data;
  logic        sd_write_enable;
  logic        sd_write_full;
  logic [15:0] sd_read_data;
  logic        sd_read_enable;
  logic        sd_read_empty;
  logic [7:0]  sd_loaded;
  logic [7:0]  sd_write_protect;
  logic        wp_switch;
  logic        sd_error;
  logic [1:0]  o_dbg_state;

  ramdisk_store #(.UNIT(0), .BLOCKS(BLOCKS)) dut (
    .clk(clk), .reset(reset),
    .sd_dev_sel(sd_dev_sel), .sd_lba(sd_lba),
    .sd_read(sd_read), .sd_write(sd_write), .sd_ready(sd_ready),
    .sd_write_data(sd_write_data), .sd_write_enable(sd_write_enable),
    .sd_write_full(sd_write_full),
    .sd_read_data(sd_read_data), .sd_read_enable(sd_read_enable),
    .sd_read_empty(sd_read_empty),
    .sd_loaded(sd_loaded), .sd_write_protect(sd_write_protect),
    .wp_switch(wp_switch), .sd_error(sd_error), .o_dbg_state(o_dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard / model ----------------
  int n_tests = 0;
  int n_fail  = 0;
  logic [15:0] model_mem [BLOCKS*256];
  logic [15:0] model_wf[$];
  logic [15:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [31:0] act,
                          input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic model_write(input int lba, input bit discard);
    int blk;
    blk = lba % BLOCKS;
    for (int w = 0; w < 256; w++) begin
      if (model_wf.size() > 0) begin
        if (!discard) model_mem[blk*256 + w] = model_wf.pop_front();
        else          void'(model_wf.pop_front());
      end
    end
  endtask

  task automatic model_read(input int lba);
    int blk;
    blk = lba % BLOCKS;
    for (int w = 0; w < 256; w++) exp_q.push_back(model_mem[blk*256 + w]);
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_wf.delete();
    exp_q.delete();
    @(negedge clk);
  endtask

  task automatic push_word(input logic [15:0] d);
    @(negedge clk);
    sd_write_data   = d;
    sd_write_enable = 1'b1;
    @(posedge clk);
    #1 sd_write_enable = 1'b0;
    if (model_wf.size() < 512) model_wf.push_back(d);
  endtask

  task automatic send_cmd(input bit wr, input bit rd, input logic [2:0] dev,
                          input logic [12:0] lba);
    @(negedge clk);
    sd_write   = wr;
    sd_read    = rd;
    sd_dev_sel = dev;
    sd_lba     = lba;
    @(posedge clk);
    #1;
    sd_write = 1'b0;
    sd_read  = 1'b0;
  endtask

  // Counts clocks from the accept edge until sd_ready is seen high again.
  task automatic wait_ready(output int cycles);
    cycles = 0;
    @(negedge clk);
    while (!sd_ready && cycles < 3000) begin
      @(negedge clk);
      cycles++;
    end
    check_eq("wait_ready", 32'(sd_ready), 32'd1);
  endtask

  // Pops the read FIFO until every expected word has been compared.
  task automatic drain();
    int guard;
    guard = 0;
    while (exp_q.size() > 0 && guard < 6000) begin
      @(negedge clk);
      if (!sd_read_empty) begin
        check_eq("rd_data", 32'(sd_read_data), 32'(exp_q.pop_front()));
        sd_read_enable = 1'b1;
      end
      @(posedge clk);
      #1 sd_read_enable = 1'b0;
      guard++;
    end
    check_eq("drain_left", 32'(exp_q.size()), 32'd0);
  endtask

  // ---------------- stimulus ----------------
  int cyc;
  int lba;

  initial begin
    reset = 1'b0; sd_dev_sel = 3'd0; sd_lba = 13'd0;
    sd_read = 1'b0; sd_write = 1'b0; sd_write_data = 16'd0;
    sd_write_enable = 1'b0; sd_read_enable = 1'b0; wp_switch = 1'b0;

    do_reset();
    check_eq("rst_ready",  32'(sd_ready), 32'd1);
    check_eq("rst_empty",  32'(sd_read_empty), 32'd1);
    check_eq("rst_full",   32'(sd_write_full), 32'd0);
    check_eq("rst_error",  32'(sd_error), 32'd0);
    check_eq("loaded",     32'(sd_loaded), 32'h01);
    check_eq("wp_off",     32'(sd_write_protect), 32'h00);

    // wrong drive number
    send_cmd(1'b0, 1'b1, 3'd2, 13'd1);
    @(negedge clk);
    check_eq("dev_err_pulse", 32'(sd_error), 32'd1);
    check_eq("dev_err_ready", 32'(sd_ready), 32'd1);
    @(negedge clk);
    check_eq("dev_err_end",   32'(sd_error), 32'd0);
    check_eq("dev_err_empty", 32'(sd_read_empty), 32'd1);
    check_eq("dev_err_ready2", 32'(sd_ready), 32'd1);

    // ramp block 5: write then read back
    for (int i = 0; i < 256; i++) push_word(16'(i));
    send_cmd(1'b1, 1'b0, 3'd0, 13'd5);
    model_write(5, 1'b0);
    wait_ready(cyc);
    check_eq("wr_busy_cycles", 32'(cyc), 32'd256);
    send_cmd(1'b0, 1'b1, 3'd0, 13'd5);
    model_read(5);
    wait_ready(cyc);
    check_eq("rd_latency", 32'(cyc), 32'd257);
    drain();
    @(negedge clk);
    check_eq("ramp_empty_after", 32'(sd_read_empty), 32'd1);

    // block 0 plus a few random blocks with random data
    for (int i = 0; i < 256; i++) push_word(16'($urandom));
    send_cmd(1'b1, 1'b0, 3'd0, 13'd0);
    model_write(0, 1'b0);
    wait_ready(cyc);
    for (int r = 0; r < 3; r++) begin
      lba = $urandom_range(1, BLOCKS - 1);
      for (int i = 0; i < 256; i++) push_word(16'($urandom));
      send_cmd(1'b1, 1'b0, 3'd0, 13'(lba));
      model_write(lba, 1'b0);
      wait_ready(cyc);
      send_cmd(1'b0, 1'b1, 3'd0, 13'(lba));
      model_read(lba);
      wait_ready(cyc);
      drain();
    end

    // write protect: block 0 must stay as it was
    @(negedge clk);
    wp_switch = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check_eq("wp_on", 32'(sd_write_protect), 32'h01);
    for (int i = 0; i < 256; i++) push_word(16'hFFFF);
    send_cmd(1'b1, 1'b0, 3'd0, 13'd0);
    model_write(0, 1'b1);
    wait_ready(cyc);
    check_eq("wp_err_pulse", 32'(sd_error), 32'd1);
    @(negedge clk);
    check_eq("wp_err_end", 32'(sd_error), 32'd0);
    wp_switch = 1'b0;
    send_cmd(1'b0, 1'b1, 3'd0, 13'd0);
    model_read(0);
    wait_ready(cyc);
    drain();

    // simultaneous read and write: write wins, stalls on empty write FIFO
    send_cmd(1'b1, 1'b1, 3'd0, 13'd3);
    @(negedge clk);
    check_eq("both_busy", 32'(sd_ready), 32'd0);
    repeat (10) @(negedge clk);
    check_eq("both_stall", 32'(sd_ready), 32'd0);
    check_eq("both_no_rd", 32'(sd_read_empty), 32'd1);
    send_cmd(1'b0, 1'b1, 3'd0, 13'd1);
    @(negedge clk);
    check_eq("busy_cmd_no_err", 32'(sd_error), 32'd0);
    for (int i = 0; i < 256; i++) push_word(16'($urandom));
    model_write(3, 1'b0);
    wait_ready(cyc);
    check_eq("both_no_rd2", 32'(sd_read_empty), 32'd1);
    send_cmd(1'b0, 1'b1, 3'd0, 13'd3);
    model_read(3);
    wait_ready(cyc);
    drain();

    // read FIFO back-pressure: two full blocks land, third stalls
    for (int b = 1; b <= 2; b++) begin
      for (int i = 0; i < 256; i++) push_word(16'($urandom));
      send_cmd(1'b1, 1'b0, 3'd0, 13'(b));
      model_write(b, 1'b0);
      wait_ready(cyc);
    end
    send_cmd(1'b0, 1'b1, 3'd0, 13'd1);
    model_read(1);
    wait_ready(cyc);
    check_eq("bp_first_nonempty", 32'(sd_read_empty), 32'd0);
    send_cmd(1'b0, 1'b1, 3'd0, 13'd2);
    model_read(2);
    wait_ready(cyc);
    check_eq("bp_second_latency", 32'(cyc), 32'd257);
    check_eq("bp_wfull_unaffected", 32'(sd_write_full), 32'd0);
    send_cmd(1'b0, 1'b1, 3'd0, 13'd5);
    model_read(5);
    repeat (20) @(negedge clk);
    check_eq("bp_third_stalled", 32'(sd_ready), 32'd0);
    drain();
    wait_ready(cyc);
    @(negedge clk);
    check_eq("bp_empty_end", 32'(sd_read_empty), 32'd1);

    // write FIFO full: 512 accepted, extra ignored, split across two blocks
    for (int i = 0; i < 513; i++) push_word(16'($urandom));
    @(negedge clk);
    check_eq("wf_full", 32'(sd_write_full), 32'd1);
    send_cmd(1'b1, 1'b0, 3'd0, 13'd10);
    model_write(10, 1'b0);
    wait_ready(cyc);
    check_eq("wf_not_full", 32'(sd_write_full), 32'd0);
    send_cmd(1'b1, 1'b0, 3'd0, 13'd11);
    model_write(11, 1'b0);
    wait_ready(cyc);
    check_eq("wf_busy_second", 32'(cyc), 32'd256);
    send_cmd(1'b0, 1'b1, 3'd0, 13'd10);
    model_read(10);
    wait_ready(cyc);
    send_cmd(1'b0, 1'b1, 3'd0, 13'd11);
    model_read(11);
    wait_ready(cyc);
    drain();

    // out-of-range block number
    send_cmd(1'b0, 1'b1, 3'd0, 13'd48);
`ifdef RAMDISK_BOUNDS_EN
    @(negedge clk);
    check_eq("oob_err", 32'(sd_error), 32'd1);
    check_eq("oob_ready", 32'(sd_ready), 32'd1);
    repeat (5) @(negedge clk);
    check_eq("oob_no_data", 32'(sd_read_empty), 32'd1);
`else
    model_read(48);
    wait_ready(cyc);
    check_eq("oob_latency", 32'(cyc), 32'd257);
    drain();
`endif

    // reset in the middle of a write
    for (int i = 0; i < 300; i++) push_word(16'($urandom));
    send_cmd(1'b1, 1'b0, 3'd0, 13'd20);
    repeat (50) @(negedge clk);
    check_eq("mid_busy", 32'(sd_ready), 32'd0);
    do_reset();
    check_eq("mid_rst_ready", 32'(sd_ready), 32'd1);
    check_eq("mid_rst_empty", 32'(sd_read_empty), 32'd1);
    check_eq("mid_rst_full",  32'(sd_write_full), 32'd0);
    check_eq("mid_rst_error", 32'(sd_error), 32'd0);
    // disk contents survive reset
    send_cmd(1'b0, 1'b1, 3'd0, 13'd5);
    model_read(5);
    wait_ready(cyc);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ramdisk_store.md
RAMDISK_STORE -- requirements
Module: ramdisk_store

Interface
REQ-001 Parameter UNIT, default 0, drive number (0..7) this RAM disk answers to.
REQ-002 Parameter BLOCKS, default 48, number of 256-word blocks stored (2 cyl x 2 surf x 12 sect).
REQ-003 clk  input  1  system clock, 20MHz; one clock; all logic on posedge clk.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 sd_dev_sel  input  3  drive select.
REQ-006 sd_lba  input  13  linear block address.
REQ-007 sd_read  input  1  one-cycle pulse: copy block lba into read FIFO.
REQ-008 sd_write  input  1  one-cycle pulse: copy 256 words from write FIFO into block lba.
REQ-009 sd_ready  output  1  high when idle and able to accept a command.
REQ-010 sd_write_data  input  16  write FIFO push data.
REQ-011 sd_write_enable  input  1  push sd_write_data into write FIFO.
REQ-012 sd_write_full  output  1  write FIFO holds 512 words.
REQ-013 sd_read_data  output  16  head of read FIFO, first-word-fall-through.
REQ-014 sd_read_enable  input  1  pop read FIFO head.
REQ-015 sd_read_empty  output  1  read FIFO holds 0 words.
REQ-016 sd_loaded  output  8  bit UNIT = 1, other bits 0.
REQ-017 sd_write_protect  output  8  bit UNIT = wp_switch, other bits 0.
REQ-018 wp_switch  input  1  front-panel write protect, sampled each cycle.
REQ-019 sd_error  output  1  one-cycle pulse on a rejected command.

Function
REQ-020 Write FIFO and read FIFO SHALL each be 512 x 16 words; push/pop in one cycle; push when full and pop when empty SHALL be ignored; simultaneous push and pop SHALL leave count unchanged.
REQ-021 sd_read_data SHALL present the head word combinationally valid whenever sd_read_empty = 0; value undefined when empty.
REQ-022 Storage SHALL be a BLOCKS*256 x 16 single-port synchronous RAM (1-cycle read latency), address = {lba, word[7:0]}.
REQ-023 State machine states: IDLE, WR_XFER, RD_XFER; sd_ready = 1 only in IDLE.
REQ-024 IDLE: sd_write pulse SHALL latch lba and dev_sel and go to WR_XFER next cycle; sd_read pulse SHALL do likewise to RD_XFER; both in the same cycle -> write wins, read dropped.
REQ-025 Commands while not IDLE SHALL be ignored without error.
REQ-026 A command with sd_dev_sel != UNIT SHALL stay IDLE and pulse sd_error the next cycle.
REQ-027 WR_XFER: each cycle the write FIFO is non-empty, pop one word and write it to RAM at word index; stall when empty; after word 255 return to IDLE (sd_ready high the following cycle).
REQ-028 WR_XFER with wp_switch latched high at command accept SHALL pop and discard all 256 words, RAM unchanged, sd_error pulsed at completion.
REQ-029 RD_XFER: issue RAM reads sequentially, push each returned word into read FIFO; stall address advance when the FIFO cannot accept the in-flight word; after word 255 pushed return to IDLE.
REQ-030 Word index SHALL be an 8-bit counter cleared on command accept; no wrap into the next block.
REQ-031 RD_XFER total latency with read FIFO drained SHALL be 257 cycles accept-to-last-push.

Reset
REQ-032 Reset SHALL force IDLE, both FIFOs empty (sd_read_empty = 1, sd_write_full = 0), sd_error = 0, word index 0; sd_ready = 1 the cycle after reset deasserts.
REQ-033 Reset mid-transfer SHALL abort; RAM words already written remain; RAM contents are never cleared by reset.

Configuration
REQ-034 Macro RAMDISK_BOUNDS_EN: defined -> a command with sd_lba >= BLOCKS SHALL be rejected as in REQ-026 (sd_error pulse, stay IDLE); undefined -> no check, address is sd_lba modulo RAM depth (upper bits ignored).

Verification
REQ-035 Push 256 words 16'o000000..16'o000377, sd_write lba=5 unit 0 -> sd_ready low 256+ cycles, then sd_read lba=5 -> read FIFO yields same 256 words in order, sd_read_empty 1 after last pop.
REQ-036 sd_read and sd_write asserted same cycle, lba=3 -> WR_XFER entered, no words appear in read FIFO.
REQ-037 sd_dev_sel=2 with UNIT=0 -> sd_error one-cycle pulse, sd_ready stays 1, FIFOs unchanged.
REQ-038 wp_switch=1, write 256 x 16'o177777 to lba=0 -> write FIFO drained, sd_error at end, readback of lba 0 unchanged.
REQ-039 sd_read lba=1 while never popping -> 256 words land, FIFO count 256; second sd_read lba=2 -> FIFO fills to 512, sd_write_full unaffected; third read stalls in RD_XFER until pops occur.
REQ-040 RAMDISK_BOUNDS_EN defined, sd_read lba=48 -> sd_error pulse, no data; undefined -> transfer runs.
